stream_width_downsizer: RTL

- Valid/ready stream serializer: accepts one IW-bit word per upstream handshake and emits it as IW/OW narrow beats on a downstream valid/ready port.
- Sits on the transmit side of the stream fabric, after a skid-buffered wide path, where a narrow consumer (byte-wide link, narrow FIFO) takes the data.
- Outputs are fully registered.
- Upstream ready is computed so that back-to-back words sustain 100% output-beat utilization.

---
 rtl/stream_width_downsizer.sv | 88 ++++++++
 1 files changed

// File: rtl/stream_width_downsizer.sv
// Valid/ready serializer: takes one IW-bit word per upstream handshake and emits it
// as IW/OW registered OW-bit beats, with full throughput on back-to-back words.
module stream_width_downsizer #(
  parameter int unsigned IW            = 32,
  parameter int unsigned OW            = 8,
  parameter bit          OPT_LSB_FIRST = 1'b1,
  parameter bit          OPT_INITIAL   = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [IW-1:0] i_data,
  input  logic          i_last,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic          o_last
);

  localparam int unsigned RATIO = IW / OW;
  localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  if ((OW > IW) || ((IW % OW) != 0)) begin : g_bad_params
    $error("stream_width_downsizer: IW must be a non-zero integer multiple of OW");
  end

  // Power-up values only matter for simulation/formal; i_reset is the real reset.
  localparam logic INIT_BIT = OPT_INITIAL ? 1'b0 : 1'bx;

  logic          valid_q = INIT_BIT;
  logic          r_last  = INIT_BIT;
  logic [CW-1:0] cnt     = {CW{INIT_BIT}};
  logic [IW-1:0] sreg;

  logic cnt_final;
  logic up_accept;
  logic dn_accept;

  assign cnt_final = (cnt == LAST_CNT);
  // i_ready -> o_ready is deliberate: the next word loads on the final beat's handshake.
  assign o_ready   = !valid_q || (i_ready && cnt_final);
  assign up_accept = i_valid && o_ready;
  assign dn_accept = valid_q && i_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      cnt     <= '0;
      r_last  <= 1'b0;
    end else if (up_accept) begin
      valid_q <= 1'b1;
      cnt     <= '0;
      r_last  <= i_last;
    end else if (dn_accept) begin
      if (cnt_final) begin
        valid_q <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: the shift register is pure datapath and is deliberately left out of reset;
  // o_valid gates its meaning, so clearing it would only cost reset fan-out.
  always_ff @(posedge i_clk) begin
    if (up_accept) begin
      sreg <= i_data;
    end else if (dn_accept && !cnt_final) begin
      if (OPT_LSB_FIRST) sreg <= sreg >> OW;
      else               sreg <= sreg << OW;
    end
  end

  assign o_valid = valid_q;
  assign o_last  = valid_q && r_last && cnt_final;

  if (OPT_LSB_FIRST) begin : g_lsb
    assign o_data = sreg[OW-1:0];
  end else begin : g_msb
    assign o_data = sreg[IW-1:IW-OW];
  end

endmodule
